// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet constants, requester state encoding and request frame byte map.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP      = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4     = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] ARP_OPER_REQUEST  = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY    = 16'h0002;
    localparam int unsigned ETH_MIN_FRAME_LEN = 60;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StGap,
        StWait,
        StDone,
        StFail
    } req_state_e;

    // Byte idx of a who-has broadcast; everything past the target IP is zero padding.
    function automatic logic [7:0] req_frame_byte(input logic [5:0]  idx,
                                                  input logic [47:0] sha,
                                                  input logic [31:0] spa,
                                                  input logic [31:0] tpa);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: b = 8'hFF;
            6'd6,  6'd22: b = sha[47:40];
            6'd7,  6'd23: b = sha[39:32];
            6'd8,  6'd24: b = sha[31:24];
            6'd9,  6'd25: b = sha[23:16];
            6'd10, 6'd26: b = sha[15:8];
            6'd11, 6'd27: b = sha[7:0];
            6'd12: b = ETH_TYPE_ARP[15:8];
            6'd13: b = ETH_TYPE_ARP[7:0];
            6'd14: b = ARP_HTYPE_ETH[15:8];
            6'd15: b = ARP_HTYPE_ETH[7:0];
            6'd16: b = ETH_TYPE_IPV4[15:8];
            6'd17: b = ETH_TYPE_IPV4[7:0];
            6'd18: b = 8'h06;
            6'd19: b = 8'h04;
            6'd20: b = ARP_OPER_REQUEST[15:8];
            6'd21: b = ARP_OPER_REQUEST[7:0];
            6'd28: b = spa[31:24];
            6'd29: b = spa[23:16];
            6'd30: b = spa[15:8];
            6'd31: b = spa[7:0];
            6'd38: b = tpa[31:24];
            6'd39: b = tpa[23:16];
            6'd40: b = tpa[15:8];
            6'd41: b = tpa[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/arp_retry_timer.sv
// Reply timeout counter and retransmission counter for the ARP requester.
module arp_retry_timer
    import arp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 12_500_000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic arm_i,
    input  logic retry_i,
    output logic expired_o,
    output logic retries_exhausted_o
);

    localparam int unsigned RTR_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    // Expiry fires on the armed cycle where the count steps onto TIMEOUT_CYCLES-1.
    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'((TIMEOUT_CYCLES >= 2) ? (TIMEOUT_CYCLES - 2) : 0);
    localparam logic [RTR_W-1:0] RTR_MAX = RTR_W'(MAX_RETRIES);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RTR_W-1:0] rtr_q, rtr_d;

    assign expired_o           = arm_i && (tmr_q == TMR_LAST);
    assign retries_exhausted_o = (rtr_q >= RTR_MAX);

    // Timer runs only while armed and falls back to zero otherwise.
    always_comb begin
        tmr_d = arm_i ? (tmr_q + 1'b1) : '0;
        rtr_d = rtr_q;
        if (retry_i && !retries_exhausted_o) begin
            rtr_d = rtr_q + 1'b1;
        end
        if (clear_i) begin
            tmr_d = '0;
            rtr_d = '0;
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
            rtr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
            rtr_q <= rtr_d;
        end
    end

endmodule

// File: rtl/arp_requester.sv
// ARP initiator: sends who-has broadcasts for a target IPv4 and waits for the matching reply.
module arp_requester
    import arp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 12_500_000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] hw_addr_i,
    input  logic [31:0] ip_addr_i,
    input  logic        start_i,
    input  logic [31:0] target_ip_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [47:0] resolved_mac_o,
    input  logic        reply_valid_i,
    input  logic [15:0] reply_oper_i,
    input  logic [31:0] reply_spa_i,
    input  logic [47:0] reply_sha_i,
    output logic [7:0]  mac_data_o,
    output logic        mac_valid_o,
    input  logic        mac_ack_i
);

    localparam int unsigned TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0]  LAST_IDX = 6'(ETH_MIN_FRAME_LEN - 1);

    req_state_e  state_q;
    logic [5:0]  idx_q;
    logic [31:0] tgt_q;
    logic [47:0] sha_q;
    logic [31:0] spa_q;
    logic        match_q;
    logic        busy_q;
    logic        done_q;
    logic        fail_q;
    logic        mac_valid_q;
    logic [7:0]  mac_data_q;
    logic [47:0] resolved_q;

    logic in_txn;
    logic match;
    logic timer_clear;
    logic timer_arm;
    logic timer_retry;
    logic timer_expired;
    logic retries_exhausted;

    assign in_txn = (state_q == StSend) || (state_q == StGap) || (state_q == StWait);
    assign match  = in_txn && reply_valid_i && (reply_oper_i == ARP_OPER_REPLY)
                    && (reply_spa_i == tgt_q);

    assign timer_clear = (state_q == StIdle) && start_i;
    assign timer_arm   = (state_q == StWait);
    // A match in the expiry cycle wins, so it must not consume a retry.
    assign timer_retry = timer_arm && timer_expired && !match && !retries_exhausted;

    arp_retry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .TMR_W         (TMR_W)
    ) u_timer (
        .clk                (clk),
        .rst                (rst),
        .clear_i            (timer_clear),
        .arm_i              (timer_arm),
        .retry_i            (timer_retry),
        .expired_o          (timer_expired),
        .retries_exhausted_o(retries_exhausted)
    );

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign fail_o         = fail_q;
    assign resolved_mac_o = resolved_q;
    assign mac_data_o     = mac_data_q;
    assign mac_valid_o    = mac_valid_q;

    // Request sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            tgt_q       <= '0;
            sha_q       <= '0;
            spa_q       <= '0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_data_q  <= '0;
            resolved_q  <= '0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            // Only the first matching reply of a resolution is kept.
            if (match && !match_q) begin
                match_q    <= 1'b1;
                resolved_q <= reply_sha_i;
            end
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        tgt_q       <= target_ip_i;
                        sha_q       <= hw_addr_i;
                        spa_q       <= ip_addr_i;
                        match_q     <= 1'b0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        mac_valid_q <= 1'b1;
                        mac_data_q  <= req_frame_byte(6'd0, hw_addr_i, ip_addr_i, target_ip_i);
                        state_q     <= StSend;
                    end
                end
                StSend: begin
                    if (mac_ack_i) begin
                        if (idx_q == LAST_IDX) begin
                            mac_valid_q <= 1'b0;
                            mac_data_q  <= '0;
                            state_q     <= StGap;
                        end else begin
                            idx_q      <= idx_q + 6'd1;
                            mac_data_q <= req_frame_byte(idx_q + 6'd1, sha_q, spa_q, tgt_q);
                        end
                    end
                end
                StGap: begin
                    if (match_q || match) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (match) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else if (timer_expired) begin
                        if (!retries_exhausted) begin
                            idx_q       <= '0;
                            mac_valid_q <= 1'b1;
                            mac_data_q  <= req_frame_byte(6'd0, sha_q, spa_q, tgt_q);
                            state_q     <= StSend;
                        end else begin
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StFail;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                StFail:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
